// File: rtl/uart0_pkg.sv
// Shared UART0 definitions: transmit FSM encoding, frame width and line levels.
package uart0_pkg;

    localparam int UART0_DATA_BITS = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart0_tx_shifter.sv
// Data-bit shift register for the UART0 transmitter: LSB-first, one shift per data bit.
module uart0_tx_shifter
    import uart0_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [UART0_DATA_BITS-1:0] load_data,
    input  logic                       shift,
    output logic                       bit_out,
    output logic                       next_bit,
    output logic                       last
);

    logic [UART0_DATA_BITS-1:0] sr;
    logic [2:0]                 idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= load_data;
            idx <= '0;
        end else if (shift) begin
            sr  <= {1'b0, sr[UART0_DATA_BITS-1:1]};
            idx <= idx + 3'd1;
        end
    end

    // next_bit lets the registered txd pick up the following bit on the same tick.
    assign bit_out  = sr[0];
    assign next_bit = sr[1];
    assign last     = (idx == 3'(UART0_DATA_BITS - 1));

endmodule

// File: rtl/uart0_tx_ctrl.sv
// UART0 transmit controller: byte handshake, baud generator enable and frame serialiser.
module uart0_tx_ctrl
    import uart0_pkg::*;
#(
    parameter int DATA_BITS = UART0_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_stop2,
    input  logic                 cfg_break,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    // Handshake: a byte moves when tx_valid and tx_ready are both high at a rising
    // clk edge; tx_ready depends only on state and cfg_break, never on tx_valid.
    tx_state_e state;
    logic      parity_en_q;
    logic      stop2_q;
    logic      parity_q;
    logic      accept;
    logic      shift;
    logic      bit_out;
    logic      next_bit;
    logic      last;

    assign tx_ready = (state == ST_IDLE) && !cfg_break;
    assign busy     = (state != ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign shift    = (state == ST_DATA) && baud_tick && !last;

    uart0_tx_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_data(tx_data),
        .shift    (shift),
        .bit_out  (bit_out),
        .next_bit (next_bit),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            txd         <= LINE_IDLE;
            baud_en     <= 1'b0;
            tx_done     <= 1'b0;
            parity_en_q <= 1'b0;
            stop2_q     <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_en <= 1'b0;
                    txd     <= cfg_break ? LINE_START : LINE_IDLE;
                    if (accept) begin
                        state       <= ST_START;
                        txd         <= LINE_START;
                        baud_en     <= 1'b1;
                        parity_en_q <= cfg_parity_en;
                        stop2_q     <= cfg_stop2;
                        parity_q    <= (^tx_data) ^ cfg_parity_odd;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state <= ST_DATA;
                        txd   <= bit_out;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (!last) begin
                            txd <= next_bit;
                        end else if (parity_en_q) begin
                            state <= ST_PARITY;
                            txd   <= parity_q;
                        end else begin
                            state <= ST_STOP1;
                            txd   <= LINE_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        state <= ST_STOP1;
                        txd   <= LINE_STOP;
                    end
                end
                ST_STOP1, ST_STOP2: begin
                    if (baud_tick) begin
                        if (state == ST_STOP1 && stop2_q) begin
                            state <= ST_STOP2;
                            txd   <= LINE_STOP;
                        end else begin
                            // Dropping baud_en here guarantees at least one idle cycle.
                            state   <= ST_IDLE;
                            txd     <= LINE_IDLE;
                            baud_en <= 1'b0;
                            tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    txd     <= LINE_IDLE;
                    baud_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart0_tx_ctrl.sv
// Self-checking bench for uart0_tx_ctrl with a divisor-0 baud generator model.
module tb_uart0_tx_ctrl;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       cfg_break = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_ready;
    logic       baud_en;
    logic       txd;
    logic       busy;
    logic       tx_done;

    int vectors = 0;
    int fails = 0;
    int gen_cnt = 0;
    int frame_no = 0;

    logic exp_q[$];
    logic cap_q[$];

    uart0_tx_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .cfg_break     (cfg_break),
        .baud_tick     (baud_tick),
        .baud_en       (baud_en),
        .txd           (txd),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock; then the baud generator model decides the tick for the coming cycle.
    // While disabled it emits random noise ticks, which the controller must ignore.
    task automatic step();
        @(posedge clk);
        #1;
        if (!baud_en) begin
            gen_cnt   = 0;
            baud_tick = 1'($urandom_range(0, 1));
        end else begin
            gen_cnt++;
            if (gen_cnt == P) begin
                baud_tick = 1'b1;
                gen_cnt   = 0;
            end else begin
                baud_tick = 1'b0;
            end
        end
    endtask

    // Reference frame: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
    function automatic void build_exp(input logic [7:0] d, input bit pe, input bit odd, input bit s2);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((($countones(d) % 2) == 1) ^ odd);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    // mode: 0 none, 1 drop cfg_stop2 mid-frame, 2 randomise all cfg mid-frame.
    task automatic run_frame(input logic [7:0] d, input bit pe, input bit odd, input bit s2,
                             input bit pre_accepted, input bit hold_next, input logic [7:0] next_d,
                             input int mode, input int abort_at);
        int  cyc;
        int  dones;
        bit  ok;
        frame_no++;
        build_exp(d, pe, odd, s2);
        if (!pre_accepted) begin
            tx_data        = d;
            cfg_parity_en  = pe;
            cfg_parity_odd = odd;
            cfg_stop2      = s2;
            tx_valid       = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (tx_ready) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            check("accept_wait", 32'(ok), 1);
            if (!ok) begin
                tx_valid = 1'b0;
                return;
            end
            step();
            if (hold_next) tx_data = next_d;
            else tx_valid = 1'b0;
            check("start_busy", 32'(busy), 1);
            check("start_txd", 32'(txd), 0);
            check("start_baud_en", 32'(baud_en), 1);
        end
        cap_q.delete();
        dones = 0;
        cyc = 0;
        while (busy && cyc < 13 * P) begin
            cap_q.push_back(txd);
            if (tx_done) dones++;
            if (abort_at != 0 && cyc == abort_at) begin
                check("pre_reset_bit3", 32'(txd), 32'(exp_q[4]));
                rst_n = 1'b0;
                #1;
                check("rst_txd", 32'(txd), 1);
                check("rst_baud_en", 32'(baud_en), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_tx_done", 32'(tx_done), 0);
                tx_valid = 1'b0;
                step();
                step();
                #2;
                rst_n = 1'b1;
                return;
            end
            if (cyc == 20 && mode == 1) cfg_stop2 = 1'b0;
            if (cyc == 20 && mode == 2) begin
                cfg_parity_en  = 1'($urandom_range(0, 1));
                cfg_parity_odd = 1'($urandom_range(0, 1));
                cfg_stop2      = 1'($urandom_range(0, 1));
                cfg_break      = 1'b1;
            end
            if (cyc == 40) cfg_break = 1'b0;
            step();
            cyc++;
        end
        check("frame_terminated", 32'(busy), 0);
        check("done_inside_frame", 32'(dones), 0);
        check("done_pulse", 32'(tx_done), 1);
        check("gap_baud_en", 32'(baud_en), 0);
        check("ready_at_done", 32'(tx_ready), 1);
        check("stop_level", 32'(txd), 1);
        check("frame_cycles", 32'(cap_q.size()), 32'(exp_q.size() * P));
        for (int b = 0; b < exp_q.size(); b++) begin
            for (int k = 0; k < P; k++) begin
                if (b * P + k < cap_q.size())
                    check($sformatf("f%0d_bit%0d", frame_no, b), 32'(cap_q[b * P + k]), 32'(exp_q[b]));
            end
        end
        step();
        if (hold_next) begin
            check("b2b_busy", 32'(busy), 1);
            check("b2b_txd", 32'(txd), 0);
            check("b2b_baud_en", 32'(baud_en), 1);
            tx_valid = 1'b0;
        end else begin
            check("done_cleared", 32'(tx_done), 0);
            check("ready_after_done", 32'(tx_ready), 1);
            check("idle_busy", 32'(busy), 0);
            check("idle_txd", 32'(txd), 1);
        end
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_txd", 32'(txd), 1);
        check("reset_baud_en", 32'(baud_en), 0);
        check("reset_tx_done", 32'(tx_done), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_tx_ready", 32'(tx_ready), 1);

        run_frame(8'h55, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        run_frame(8'hA3, 1, 0, 0, 0, 0, 8'h00, 0, 0);
        run_frame(8'hA3, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        run_frame(8'h00, 0, 0, 1, 0, 0, 8'h00, 1, 0);

        run_frame(8'h01, 0, 0, 0, 0, 1, 8'h80, 0, 0);
        run_frame(8'h80, 0, 0, 0, 1, 0, 8'h00, 0, 0);

        // Reset lands in data bit 3 (cycles 64..79 after accept); bit 3 of 0x37 is 0.
        run_frame(8'h37, 0, 0, 0, 0, 0, 8'h00, 0, 70);
        step();
        check("post_reset_ready", 32'(tx_ready), 1);
        run_frame(8'hFF, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        cfg_break = 1'b1;
        tx_data   = 8'h3C;
        tx_valid  = 1'b1;
        repeat (4) step();
        check("break_txd", 32'(txd), 0);
        check("break_ready", 32'(tx_ready), 0);
        check("break_busy", 32'(busy), 0);
        check("break_baud_en", 32'(baud_en), 0);
        cfg_break = 1'b0;
        #1;
        check("break_release_ready", 32'(tx_ready), 1);
        run_frame(8'h3C, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        for (int n = 0; n < 8; n++) begin
            run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 0, 0, 8'h00, 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
